custkey_index_search: RTL and testbench

Reverse lookup for the 32-bit custom key table. Given a 32-bit custom key, the block recovers the 4-bit key index that selects it by scanning the 16 table entries sequentially, one entry per clock. It sits beside the key-index-to-custom-key table in the key schedule path. Key-management logic uses it to validate received or stored custom keys and to map them back to an index, with a start/busy/done handshake.

---
 rtl/custkey_index_search.sv | 115 +++++++++++
 tb/tb_custkey_index_search.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/custkey_index_search.sv
// Reverse lookup for the 32-bit custom key table: scans 16 entries, one per clock,
// and returns the index of the entry matching the requested key.
module custkey_index_search #(
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] custkey_in,
  output logic        busy,
  output logic        done,
  output logic        found,
  output logic [3:0]  key_idx
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t      state, state_nxt;
  logic [3:0]  idx;
  logic [31:0] key;
  logic        hit;
  logic [3:0]  hit_idx;
  logic        match;
  logic        last;

  function automatic logic [31:0] tbl(input logic [3:0] i);
    case (i)
      4'd0:    tbl = 32'h8899AABB;
      4'd1:    tbl = 32'hCCDDEEFF;
      4'd2:    tbl = 32'hABCD1234;
      4'd3:    tbl = 32'hA1B2C3D4;
      4'd4:    tbl = 32'h5E6F7081;
      4'd5:    tbl = 32'h9A0BCDEF;
      4'd6:    tbl = 32'h12345678;
      4'd7:    tbl = 32'h89ABCDEF;
      4'd8:    tbl = 32'h0F1E2D3C;
      4'd9:    tbl = 32'h4B5A6978;
      4'd10:   tbl = 32'hFEDCBA98;
      4'd11:   tbl = 32'h76543210;
      4'd12:   tbl = 32'hDEADBEEF;
      4'd13:   tbl = 32'hCAFEBABE;
      4'd14:   tbl = 32'h00112233;
      default: tbl = 32'h44556677;
    endcase
  endfunction

  assign match = (tbl(idx) == key);
  assign last  = (idx == 4'hF);
  assign busy  = (state != IDLE);
  assign done  = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SCAN;
      SCAN:    if ((EARLY_EXIT && match) || last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx     <= '0;
      key     <= '0;
      hit     <= 1'b0;
      hit_idx <= '0;
      found   <= 1'b0;
      key_idx <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          key     <= custkey_in;
          idx     <= '0;
          hit     <= 1'b0;
          hit_idx <= '0;
          found   <= 1'b0;
          key_idx <= '0;
        end
        SCAN: begin
          if (EARLY_EXIT) begin
            if (match) begin
              found   <= 1'b1;
              key_idx <= idx;
            end else if (last) begin
              found   <= 1'b0;
              key_idx <= '0;
            end else begin
              idx <= idx + 4'd1;
            end
          end else begin
            // Constant-time: remember only the first match, publish at the end.
            if (match && !hit) begin
              hit     <= 1'b1;
              hit_idx <= idx;
            end
            if (last) begin
              found   <= hit | match;
              key_idx <= hit ? hit_idx : (match ? idx : 4'd0);
            end else begin
              idx <= idx + 4'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_custkey_index_search.sv
// Directed bench for custkey_index_search; one instance per EARLY_EXIT setting.
module tb_custkey_index_search;

  logic        clk = 1'b0;
  logic        rst;
  logic        start1, start0;
  logic [31:0] key1, key0;
  logic        busy1, done1, found1;
  logic        busy0, done0, found0;
  logic [3:0]  idx1, idx0;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  custkey_index_search #(.EARLY_EXIT(1'b1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .custkey_in(key1),
    .busy(busy1), .done(done1), .found(found1), .key_idx(idx1)
  );

  custkey_index_search #(.EARLY_EXIT(1'b0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .custkey_in(key0),
    .busy(busy0), .done(done0), .found(found0), .key_idx(idx0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Start a search on the chosen instance and wait (bounded) for done.
  // Returns cycles from the accepted start cycle to the done cycle.
  task automatic launch(input bit ee, input logic [31:0] k, input string tag, output int lat);
    if (ee) begin start1 = 1'b1; key1 = k; end
    else    begin start0 = 1'b1; key0 = k; end
    tick();
    start1 = 1'b0; start0 = 1'b0;
    key1 = 32'h0; key0 = 32'h0;
    chk({tag, "_busy"}, ee ? busy1 : busy0, 1'b1);
    lat = 1;
    while (!(ee ? done1 : done0) && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  task automatic search(input bit ee, input logic [31:0] k, input int exp_lat,
                        input logic exp_f, input logic [3:0] exp_i, input string tag);
    int lat;
    launch(ee, k, tag, lat);
    chk({tag, "_lat"},   lat, exp_lat);
    chk({tag, "_found"}, ee ? found1 : found0, exp_f);
    chk({tag, "_idx"},   ee ? idx1 : idx0, exp_i);
    tick();
    chk({tag, "_idle"},  ee ? busy1 : busy0, 1'b0);
  endtask

  initial begin
    int ndone;
    int lat;
    rst = 1'b1; start1 = 0; start0 = 0; key1 = 0; key0 = 0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_busy1",  busy1,  1'b0);
    chk("rst_done1",  done1,  1'b0);
    chk("rst_found1", found1, 1'b0);
    chk("rst_idx1",   idx1,   4'd0);
    chk("rst_busy0",  busy0,  1'b0);
    chk("rst_found0", found0, 1'b0);
    ndone = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done1 || done0 || busy1 || busy0) ndone++;
    end
    chk("idle_no_done", ndone, 0);

    // Early-exit instance
    search(1'b1, 32'hDEADBEEF, 14, 1'b1, 4'd12, "ee1_deadbeef");
    tick(); tick();
    chk("hold_found", found1, 1'b1);
    chk("hold_idx",   idx1,   4'd12);
    search(1'b1, 32'h8899AABB, 2,  1'b1, 4'd0,  "ee1_first");
    search(1'b1, 32'h44556677, 17, 1'b1, 4'd15, "ee1_last");
    search(1'b1, 32'h00000000, 17, 1'b0, 4'd0,  "ee1_miss");

    // Starts while busy (mid-scan and on the DONE cycle) are dropped
    start1 = 1'b1; key1 = 32'hCAFEBABE;
    tick();
    start1 = 1'b0; key1 = 32'h0;
    lat = 1; ndone = 0;
    while (!done1 && lat < 40) begin
      if (lat == 5) begin start1 = 1'b1; key1 = 32'hDEADBEEF; end
      tick();
      start1 = 1'b0;
      lat++;
    end
    chk("busy_lat",   lat,    15);
    chk("busy_idx",   idx1,   4'd13);
    chk("busy_found", found1, 1'b1);
    start1 = 1'b1; key1 = 32'hDEADBEEF;
    tick();
    start1 = 1'b0;
    chk("done_start_ignored", busy1, 1'b0);
    chk("no_second_done",     done1, 1'b0);
    chk("held_after_ignore",  idx1,  4'd13);
    search(1'b1, 32'h12345678, 8, 1'b1, 4'd6, "b2b");

    // Reset in the middle of a scan
    start1 = 1'b1; key1 = 32'hA1B2C3D4;
    tick();
    start1 = 1'b0; key1 = 32'h0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy",  busy1,  1'b0);
    chk("abort_done",  done1,  1'b0);
    chk("abort_found", found1, 1'b0);
    chk("abort_idx",   idx1,   4'd0);
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done1) ndone++;
    end
    chk("abort_no_done", ndone, 0);
    search(1'b1, 32'hFEDCBA98, 12, 1'b1, 4'd10, "after_abort");

    // Constant-time instance
    search(1'b0, 32'h8899AABB, 17, 1'b1, 4'd0,  "ee0_first");
    search(1'b0, 32'hDEADBEEF, 17, 1'b1, 4'd12, "ee0_deadbeef");
    search(1'b0, 32'h00000000, 17, 1'b0, 4'd0,  "ee0_miss");
    search(1'b0, 32'h44556677, 17, 1'b1, 4'd15, "ee0_last");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
